// File: rtl/factor_digit_sequencer.sv
// Seven-segment display sequencer: buffers prime factors in a small FIFO and shows each
// one as two hex digits, followed by a blank gap, or by a dash after the last factor.
module factor_digit_sequencer #(
    parameter int MAX_COUNT  = 10_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_factor,
    input  logic       in_last,
    output logic       in_ready,
    output logic [6:0] segments,
    output logic       dp,
    output logic       busy,
    output logic       done
);

    localparam int CW  = $clog2(MAX_COUNT + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(MAX_COUNT - 1);
    localparam logic [FCW-1:0] FULL_COUNT = FCW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_GAP  = 3'd3,
        ST_DASH = 3'd4
    } state_t;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    state_t          state_r, next_state_s;
    logic [CW-1:0]   cnt_r;
    logic            phase_end_s;
    logic [8:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [FCW-1:0]  count_r;
    logic [8:0]      head_s;
    logic [8:0]      disp_r;
    logic            push_s, pop_s, nonempty_s;
    logic [6:0]      seg_next_s, seg_r;
    logic            dp_next_s, dp_r, done_next_s, done_r;

    // Acceptance looks only at the registered count, so a same-cycle pop never frees a slot.
    assign in_ready    = (count_r != FULL_COUNT);
    assign nonempty_s  = (count_r != {FCW{1'b0}});
    assign push_s      = in_valid && in_ready;
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign phase_end_s = (cnt_r == CNT_LAST);
    assign busy        = (state_r != ST_IDLE) || nonempty_s;
    assign segments    = seg_r;
    assign dp          = dp_r;
    assign done        = done_r;

    // FIFO storage write; stale entries are harmless because pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fifo_mem_r[wr_ptr_r] <= {in_last, in_factor};
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {FCW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + FCW'(1);
                2'b01:   count_r <= count_r - FCW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // State register, phase counter and display latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            disp_r  <= 9'd0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) cnt_r <= {CW{1'b0}};
            else if (!phase_end_s)        cnt_r <= cnt_r + CW'(1);
            else                          cnt_r <= cnt_r;
            if (pop_s) disp_r <= head_s;
        end
    end

    // Next-state logic; GAP and DASH share the same exit behaviour.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (nonempty_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_HI;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HI: begin
                if (phase_end_s) next_state_s = ST_LO;
                else             next_state_s = ST_HI;
            end
            ST_LO: begin
                if (phase_end_s) next_state_s = disp_r[8] ? ST_DASH : ST_GAP;
                else             next_state_s = ST_LO;
            end
            ST_GAP, ST_DASH: begin
                if (phase_end_s && nonempty_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_HI;
                end else if (phase_end_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        seg_next_s  = 7'h00;
        dp_next_s   = 1'b0;
        done_next_s = (state_r == ST_DASH) && phase_end_s;
        case (next_state_s)
            ST_IDLE: begin
                seg_next_s = 7'h00;
                dp_next_s  = 1'b0;
            end
            ST_HI: begin
                seg_next_s = hex_glyph(pop_s ? head_s[7:4] : disp_r[7:4]);
                dp_next_s  = 1'b1;
            end
            ST_LO:   seg_next_s = hex_glyph(disp_r[3:0]);
            ST_GAP:  seg_next_s = 7'h00;
            ST_DASH: seg_next_s = 7'h40;
            default: seg_next_s = 7'h00;
        endcase
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r  <= 7'h00;
            dp_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            seg_r  <= seg_next_s;
            dp_r   <= dp_next_s;
            done_r <= done_next_s;
        end
    end

endmodule

// File: tb/tb_factor_digit_sequencer.sv
// Bench for factor_digit_sequencer: directed scenarios plus random traffic, compared every
// cycle against a per-factor timeline model (each factor spans 3*MC display cycles).
module tb_factor_digit_sequencer;

    localparam int MC    = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_factor;
    logic       in_last;
    logic       in_ready;
    logic [6:0] segments;
    logic       dp;
    logic       busy;
    logic       done;

    factor_digit_sequencer #(.MAX_COUNT(MC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_factor(in_factor),
        .in_last(in_last), .in_ready(in_ready), .segments(segments), .dp(dp),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int done_gap = 0;

    // Reference model: pending factors plus the one currently on the display.
    logic [8:0] m_q[$];
    bit         m_active = 1'b0;
    logic [7:0] m_fac = 8'd0;
    bit         m_last = 1'b0;
    int         m_t = 0;
    bit         m_done = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  sz;
        bit  psh, fin, pop;
        logic [8:0] e;
        sz  = m_q.size();
        psh = in_valid && (sz < DEPTH);
        fin = m_active && (m_t == 3 * MC - 1);
        pop = (sz > 0) && (!m_active || fin);
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_done   = 1'b0;
        end else begin
            m_done = fin && m_last;
            if (pop) begin
                e        = m_q.pop_front();
                m_fac    = e[7:0];
                m_last   = e[8];
                m_active = 1'b1;
                m_t      = 0;
            end else if (fin) begin
                m_active = 1'b0;
                m_t      = 0;
            end else if (m_active) begin
                m_t++;
            end
            if (psh) m_q.push_back({in_last, in_factor});
        end
    endtask

    function automatic logic [6:0] exp_seg();
        if (!m_active)       return 7'h00;
        else if (m_t < MC)   return glyph_tab[m_fac[7:4]];
        else if (m_t < 2*MC) return glyph_tab[m_fac[3:0]];
        else                 return m_last ? 7'h40 : 7'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_val("segments", 32'(segments), 32'(exp_seg()));
        check_val("dp",       32'(dp),       32'(m_active && (m_t < MC)));
        check_val("done",     32'(done),     32'(m_done));
        check_val("busy",     32'(busy),     32'(m_active || (m_q.size() > 0)));
        check_val("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
        if (done) begin
            if (done_cnt > 0) done_gap = cyc - last_done_cyc;
            last_done_cyc = cyc;
            done_cnt++;
        end
    endtask

    task automatic push(input logic [7:0] f, input logic l);
        int budget;
        bit acc;
        budget    = 200;
        acc       = 1'b0;
        in_valid  = 1'b1;
        in_factor = f;
        in_last   = l;
        while (!acc && budget > 0) begin
            acc = in_ready;
            tick();
            budget--;
        end
        in_valid = 1'b0;
        check_val("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (busy && b < 1000) begin
            tick();
            b++;
        end
        check_val("drain_busy", 32'(busy), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_factor = 8'h55;
        in_last   = 1'b1;

        // Reset held two cycles with a valid factor present: nothing may be queued.
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Single factor 0x2D as a complete number.
        push(8'h2D, 1'b1);
        drain();

        // 45 = 3*3*5.
        push(8'h03, 1'b0);
        push(8'h03, 1'b0);
        push(8'h05, 1'b1);
        drain();

        // Backpressure: six distinct factors held back to back.
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        push(8'h55, 1'b0);
        push(8'h66, 1'b1);
        drain();

        // Reset while the first factor is in its high-digit phase with three queued.
        push(8'hA1, 1'b0);
        push(8'hB2, 1'b0);
        push(8'hC3, 1'b0);
        push(8'hD4, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3 * MC + 4; i++) tick();

        // Two one-factor numbers back to back.
        done_cnt = 0;
        done_gap = 0;
        push(8'h07, 1'b1);
        push(8'h0B, 1'b1);
        drain();
        check_val("done_pulses",  32'(done_cnt), 32'd2);
        check_val("done_spacing", 32'(done_gap), 32'(3 * MC));

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 2) == 0);
            in_factor = 8'($urandom);
            in_last   = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/factor_digit_sequencer.md
# factor_digit_sequencer

Display stage that sits directly downstream of the factorizer core in `tt_um_marno_factorize`. It accepts the prime factors of a number over a valid/ready handshake and buffers them in a small FIFO. It then shows each factor on the seven-segment output as two hex digits, each held for `MAX_COUNT` cycles, and ends each number with a dash. Its `segments`/`dp` outputs drive `uo_out[7:0]` at the top level.

## Interface
- `MAX_COUNT`, 10_000_000: cycles each display phase is held; must be ≥1. Benches use small values.
- `FIFO_DEPTH`, 4: factor FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream has a factor on `in_factor`.
- `in_factor`  in  8  factor value, unsigned.
- `in_last`  in  1  factor is the final one of the current number.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `segments`  out  7  active-high segments; bit0=a … bit6=g; registered.
- `dp`  out  1  decimal point; lit while the high digit is shown; registered.
- `busy`  out  1  state≠IDLE or FIFO non-empty.
- `done`  out  1  one-cycle pulse at the end of a number's DASH phase.

## Operation
- Push: on a rising edge where `in_valid && in_ready`, {`in_last`,`in_factor`} is written at the tail.
- The push decision uses only the registered count. A pop in the same cycle does not make a full FIFO accept.
- FSM states: IDLE, HI, LO, GAP, DASH.
- **IDLE**
  - `segments`=0, `dp`=0.
  - If the FIFO is non-empty, pop the head into the display register and go to HI.
- **HI**
  - Shows the hex glyph of factor[7:4] with `dp`=1.
  - After `MAX_COUNT` cycles, go to LO.
- **LO**
  - Shows the glyph of factor[3:0] with `dp`=0.
  - After `MAX_COUNT` cycles, go to DASH if the stored last flag is set, else to GAP.
- **GAP**
  - `segments`=0.
  - After `MAX_COUNT` cycles: if the FIFO is non-empty, pop and go to HI directly; else go to IDLE.
- **DASH**
  - `segments`=0x40.
  - After `MAX_COUNT` cycles, pulse `done` and then behave as GAP exit: pop→HI, or go to IDLE.
- Leading zeros are not suppressed: 0x07 displays as "0" then "7".
- Glyphs (hex segment codes):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Phase counter
  - Counts 0..`MAX_COUNT`-1 and clears on every state transition.
  - Width is $clog2(MAX_COUNT+1).
  - It never wraps within a phase.
- FIFO
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Occupancy count is 0..`FIFO_DEPTH`.
  - Factor order is preserved exactly.
- Reset:
  - FIFO is emptied and queued factors are discarded.
  - FSM returns to IDLE and the counter clears.
  - `segments`=0, `dp`=0, `done`=0.
  - `busy`=0 and `in_ready`=1 from the first edge after `rst` is sampled high.
  - Reset mid-phase applies immediately, with no completion of the current phase.

## Timing
- Handshake latency:
  - A factor pushed at edge k into an empty FIFO with FSM in IDLE is popped at edge k+1.
  - The high digit is visible after edge k+1.
- Each of HI, LO, GAP and DASH lasts exactly `MAX_COUNT` cycles, so a factor occupies 3×`MAX_COUNT` cycles.
- A last factor occupies HI, LO and DASH only. No GAP follows it before an immediate next pop.
- `done`
  - Asserts for the cycle following the final DASH cycle, i.e. coincident with the first HI or IDLE cycle.
  - It never asserts two cycles in a row.
- `in_ready` is combinational from the registered count only, with no path from `in_valid`.
- Simultaneous push and pop with a non-full FIFO: count is unchanged and both take effect.

## Test plan
- **Reset:** hold `rst` 2 cycles with `in_valid`=1.
  - Expected: `segments`=0, `dp`=0, `done`=0, `busy`=0, `in_ready`=1, and no entry is queued.
- **Single factor, `MAX_COUNT`=4:** push 0x2D with `last`=1.
  - Expected: 4 cycles of 0x5B with `dp`=1, then 4 cycles of 0x5E with `dp`=0, then 4 cycles of 0x40.
  - Then a one-cycle `done`, `segments`=0, and `busy`=0.
- **Multi-factor number (45 = 3·3·5):** push 0x03, 0x03, 0x05(`last`).
  - Expected sequence: 3F/4F/blank, 3F/4F/blank, 3F/6D/40, then `done`.
  - Each phase lasts 4 cycles.
- **Backpressure:** hold `in_valid` with 6 distinct factors back to back.
  - Expected: 5 accepted (first popped immediately), then `in_ready` drops.
  - The 6th is accepted only after the next GAP-exit pop.
  - Display order matches push order.
- **Reset mid-operation:** assert `rst` during HI with 3 factors queued.
  - Expected: next cycle `segments`=0, `dp`=0, `busy`=0.
  - After release, nothing is displayed until a new push.
- **Back-to-back numbers:** push 0x07(`last`) then 0x0B(`last`).
  - Expected: 0/7/dash, then `done`, then 0/b/dash, then `done`.
  - Exactly two `done` pulses, separated by 3×`MAX_COUNT` cycles.
